// File: rtl/scrambler_pkg.sv
// Shared constants and helpers for the multi-lane 64b/66b scrambler (x^58 + x^39 + 1).
package scrambler_pkg;

    localparam int unsigned STATE_W = 58;
    localparam int unsigned TAP_A   = 38;
    localparam int unsigned TAP_B   = 57;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam logic [STATE_W-1:0] DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    typedef enum logic {
        ModeScramble   = 1'b0,
        ModeDescramble = 1'b1
    } mode_e;

    function automatic logic hdr_invalid(input logic [1:0] sync);
        return (sync != HDR_DATA) && (sync != HDR_CTRL);
    endfunction

endpackage

// File: rtl/scrambler_lane.sv
// One lane: self-synchronous bit loop, 58-bit state, bypass and header-error counter.
module scrambler_lane
    import scrambler_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 64,
    parameter int unsigned          CNT_WIDTH  = 16,
    parameter logic [STATE_W-1:0]   SEED       = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xfer,
    input  mode_e                 mode,
    input  logic                  seed_load,
    input  logic                  bypass,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            sync,
    output logic [DATA_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [STATE_W-1:0]    s;
    logic [DATA_WIDTH-1:0] scr;
    logic                  fb;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Bit 0 enters first; feedback is the line-side bit (output when scrambling,
    // input when descrambling), which is what makes the descrambler self-sync.
    always_comb begin
        s   = state_q;
        scr = '0;
        fb  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            scr[i] = data[i] ^ s[TAP_A] ^ s[TAP_B];
            fb     = (mode == ModeDescramble) ? data[i] : scr[i];
            s      = {s[STATE_W-2:0], fb};
        end
    end

    assign result = bypass ? data : scr;

    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = SEED;
        end else if (xfer && !bypass) begin
            state_d = s;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (xfer && (mode == ModeDescramble) && hdr_invalid(sync) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;

endmodule

// File: rtl/scrambler_multilane.sv
// Multi-lane 64b/66b scrambler/descrambler with a registered valid/ready output stage.
module scrambler_multilane
    import scrambler_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH = 64,
    parameter int unsigned        NUM_LANES  = 4,
    parameter logic [STATE_W-1:0] SEED       = DEFAULT_SEED,
    parameter int unsigned        CNT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                descramble_mode,
    input  logic                                seed_load,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     in_data,
    input  logic [NUM_LANES*2-1:0]              in_sync,
    input  logic [NUM_LANES-1:0]                in_bypass,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_LANES*(DATA_WIDTH+2)-1:0] out_data,
    input  logic                                hdr_err_clr,
    output logic [NUM_LANES*CNT_WIDTH-1:0]      hdr_err_cnt
);

    localparam int unsigned LANE_W = DATA_WIDTH + 2;

    logic                              xfer;
    logic [NUM_LANES*DATA_WIDTH-1:0]   lane_y;
    logic [NUM_LANES*LANE_W-1:0]       out_d;

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        scrambler_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH),
            .SEED       (SEED)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .xfer      (xfer),
            .mode      (mode_e'(descramble_mode)),
            .seed_load (seed_load),
            .bypass    (in_bypass[k]),
            .err_clr   (hdr_err_clr),
            .data      (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .sync      (in_sync[2*k +: 2]),
            .result    (lane_y[k*DATA_WIDTH +: DATA_WIDTH]),
            .err_cnt   (hdr_err_cnt[k*CNT_WIDTH +: CNT_WIDTH])
        );

        assign out_d[k*LANE_W +: LANE_W] = {in_sync[2*k +: 2], lane_y[k*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Output register only loads on a transfer, so a stalled beat stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= out_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scrambler_multilane.sv
// Scoreboard bench for scrambler_multilane: directed beats, hand-derived vectors, loopback.
module tb_scrambler_multilane;

    localparam int DW = 64;
    localparam int NL = 4;
    localparam int CW = 16;
    localparam int LW = DW + 2;
    localparam logic [57:0] SEED_V = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] HAND_ZERO = 64'h03FF_FF80_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               descramble_mode;
    logic               seed_load;
    logic               in_valid;
    logic               in_ready;
    logic [NL*DW-1:0]   in_data;
    logic [NL*2-1:0]    in_sync;
    logic [NL-1:0]      in_bypass;
    logic               out_valid;
    logic               out_ready;
    logic [NL*LW-1:0]   out_data;
    logic               hdr_err_clr;
    logic [NL*CW-1:0]   hdr_err_cnt;

    always #5 clk = ~clk;

    scrambler_multilane #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .SEED       (SEED_V),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .descramble_mode (descramble_mode),
        .seed_load       (seed_load),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_sync         (in_sync),
        .in_bypass       (in_bypass),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .hdr_err_clr     (hdr_err_clr),
        .hdr_err_cnt     (hdr_err_cnt)
    );

    logic [NL*LW-1:0] sb_q[$];
    logic [NL*LW-1:0] mon_exp;
    int               checks = 0;
    int               failures = 0;
    logic [57:0]      m_state[NL];
    logic [CW-1:0]    m_cnt[NL];

    task automatic check(input string name, input logic [NL*LW-1:0] act, input logic [NL*LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Line-bit recurrence: out[n] = in[n] ^ line[n-39] ^ line[n-58]; line[] holds the
    // scrambled stream, oldest bit first.
    function automatic void model_lane(input logic [57:0] st, input logic [DW-1:0] x,
                                       input logic desc, output logic [DW-1:0] y,
                                       output logic [57:0] st_n);
        logic line [58+DW];
        for (int j = 0; j < 58; j++) line[j] = st[57-j];
        for (int i = 0; i < DW; i++) begin
            y[i] = x[i] ^ line[i] ^ line[i+19];
            line[58+i] = desc ? x[i] : y[i];
        end
        for (int k = 0; k < 58; k++) st_n[k] = line[58+DW-1-k];
    endfunction

    task automatic prep(input logic [NL*DW-1:0] d, input logic [2*NL-1:0] s,
                        input logic [NL-1:0] byp, input logic desc, input logic sl,
                        input logic clr, output logic [NL*LW-1:0] exp);
        logic [DW-1:0] y;
        logic [57:0]   stn;
        for (int k = 0; k < NL; k++) begin
            model_lane(m_state[k], d[k*DW +: DW], desc, y, stn);
            if (byp[k]) begin
                y   = d[k*DW +: DW];
                stn = m_state[k];
            end
            exp[k*LW +: LW] = {s[2*k +: 2], y};
            m_state[k] = sl ? SEED_V : stn;
            if (clr) m_cnt[k] = '0;
            else if (desc && (s[2*k +: 2] == 2'b00 || s[2*k +: 2] == 2'b11) && m_cnt[k] != '1)
                m_cnt[k] = m_cnt[k] + 1'b1;
        end
        sb_q.push_back(exp);
        in_data = d;
        in_sync = s;
        in_bypass = byp;
        descramble_mode = desc;
        seed_load = sl;
        hdr_err_clr = clr;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [NL*DW-1:0] d, input logic [2*NL-1:0] s,
                        input logic [NL-1:0] byp, input logic desc, input logic sl,
                        input logic clr, output logic [NL*LW-1:0] exp);
        int waitc = 0;
        prep(d, s, byp, desc, sl, clr, exp);
        while (!in_ready && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        seed_load = 1'b0;
        hdr_err_clr = 1'b0;
    endtask

    task automatic seed_pulse();
        seed_load = 1'b1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        for (int k = 0; k < NL; k++) m_state[k] = SEED_V;
    endtask

    function automatic logic [NL*CW-1:0] model_cnt();
        logic [NL*CW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*CW +: CW] = m_cnt[k];
        return v;
    endfunction

    // Monitor: every accepted output beat is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %h required none", out_data);
            end else begin
                mon_exp = sb_q.pop_front();
                check("out_beat", out_data, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*LW-1:0] e;
        logic [NL*LW-1:0] exp_a;
        logic [NL*DW-1:0] orig [100];
        logic [2*NL-1:0]  osync [100];
        logic [NL*DW-1:0] scr [100];
        logic [NL*DW-1:0] d1, d2, d3;
        logic [NL*LW-1:0] e1, e2, e3;
        int waitc;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sync = {NL{2'b01}};
        in_bypass = '0;
        descramble_mode = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b1;
        hdr_err_clr = 1'b0;
        for (int k = 0; k < NL; k++) begin
            m_state[k] = SEED_V;
            m_cnt[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_hdr_cnt", hdr_err_cnt, '0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hand-derived: all-ones seed, zero data -> taps first differ at bit 39.
        send('0, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);
        check("latency_valid", out_valid, 1'b1);
        check("hand_zero", out_data, {NL{2'b01, HAND_ZERO}});

        send({NL{64'hFFFF_FFFF_FFFF_FFFF}}, {NL{2'b10}}, '0, 1'b0, 1'b0, 1'b0, e);
        send({64'h0123_4567_89AB_CDEF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
              64'h8000_0000_0000_0001}, 8'b01_10_01_10, '0, 1'b0, 1'b0, 1'b0, e);
        send({64'hCAFE_F00D_1234_0000, 64'h0, 64'hFFFF_0000_FFFF_0000, 64'h1},
             8'b10_10_01_01, '0, 1'b1, 1'b0, 1'b0, e);

        // Bypass lane 1, then an unbypassed beat continues from lane 1's held state.
        send({64'h1111_2222_3333_4444, 64'h5, 64'hDEAD_BEEF_0123_4567, 64'h7},
             {NL{2'b01}}, 4'b0010, 1'b0, 1'b0, 1'b0, e);
        check("bypass_lane1", out_data[LW +: LW], {2'b01, 64'hDEAD_BEEF_0123_4567});
        send({NL{64'h0F0F_0F0F_0F0F_0F0F}}, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);

        // seed_load with a transfer: this beat uses old state, next beat starts from SEED.
        send({NL{64'h1357_9BDF_2468_ACE0}}, {NL{2'b01}}, '0, 1'b0, 1'b1, 1'b0, e);
        send('0, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);
        check("seed_reload_zero", out_data, {NL{2'b01, HAND_ZERO}});

        // Backpressure: stall 5 cycles with a second beat pending.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send({NL{64'hA5A5_0000_5A5A_FFFF}}, {NL{2'b10}}, '0, 1'b0, 1'b0, 1'b0, exp_a);
        prep({NL{64'h0000_1111_2222_3333}}, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, exp_a);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send({NL{64'h0000_0000_0000_0003}}, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);

        // Wrong-seed self-sync: descramble a stream with the state left by scrambling it.
        seed_pulse();
        d1 = {64'h1, 64'h2, 64'h3, 64'h4};
        d2 = {64'hFEDC_BA98_7654_3210, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0002_0003_0004};
        d3 = {64'h9999_8888_7777_6666, 64'h1234, 64'h8000_0000_0000_0000, 64'h5};
        send(d1, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e1);
        send(d2, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e2);
        send(d3, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e3);
        for (int k = 0; k < NL; k++) begin
            d1[k*DW +: DW] = e1[k*LW +: DW];
            d2[k*DW +: DW] = e2[k*LW +: DW];
            d3[k*DW +: DW] = e3[k*LW +: DW];
        end
        send(d1, {NL{2'b01}}, '0, 1'b1, 1'b0, 1'b0, e);
        send(d2, {NL{2'b01}}, '0, 1'b1, 1'b0, 1'b0, e);
        check("selfsync_beat2", out_data, {2'b01, 64'hFEDC_BA98_7654_3210, 2'b01, 64'h0,
                                           2'b01, 64'hFFFF_FFFF_FFFF_FFFF,
                                           2'b01, 64'h0001_0002_0003_0004});
        send(d3, {NL{2'b01}}, '0, 1'b1, 1'b0, 1'b0, e);
        check("selfsync_beat3", out_data, {2'b01, 64'h9999_8888_7777_6666, 2'b01, 64'h1234,
                                           2'b01, 64'h8000_0000_0000_0000, 2'b01, 64'h5});

        // Loopback through the same instance: scramble from SEED, reload, descramble.
        seed_pulse();
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < NL; k++) begin
                orig[i][k*DW +: DW] = {$urandom, $urandom};
                osync[i][2*k +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            end
            send(orig[i], osync[i], '0, 1'b0, 1'b0, 1'b0, e);
            for (int k = 0; k < NL; k++) scr[i][k*DW +: DW] = e[k*LW +: DW];
        end
        seed_pulse();
        for (int i = 0; i < 100; i++) begin
            send(scr[i], osync[i], '0, 1'b1, 1'b0, 1'b0, e);
            for (int k = 0; k < NL; k++) begin
                check("loopback", out_data[k*LW +: LW], {osync[i][2*k +: 2], orig[i][k*DW +: DW]});
            end
        end

        // Header errors on lane 2 (descramble only), then clear beating a same-cycle error.
        send({NL{64'h42}}, 8'b01_00_01_01, '0, 1'b1, 1'b0, 1'b0, e);
        send({NL{64'h43}}, 8'b01_11_01_01, 4'b0100, 1'b1, 1'b0, 1'b0, e);
        send({NL{64'h44}}, 8'b01_01_01_01, '0, 1'b1, 1'b0, 1'b0, e);
        check("hdr_cnt_lane2", hdr_err_cnt[2*CW +: CW], 16'd2);
        check("hdr_cnt_all", hdr_err_cnt, model_cnt());
        send({NL{64'h45}}, 8'b01_00_01_01, '0, 1'b0, 1'b0, 1'b0, e);
        check("hdr_scramble_ignored", hdr_err_cnt[2*CW +: CW], 16'd2);
        send({NL{64'h46}}, 8'b01_11_01_01, '0, 1'b1, 1'b0, 1'b1, e);
        check("hdr_clr_priority", hdr_err_cnt[2*CW +: CW], 16'd0);

        // Saturation: 2^16+3 errors on lane 2, all lanes bypassed so data is a pass-through.
        for (int i = 0; i < 65539; i++) begin
            send({NL{64'(i)}}, 8'b01_00_01_01, '1, 1'b1, 1'b0, 1'b0, e);
        end
        check("hdr_saturate", hdr_err_cnt[2*CW +: CW], 16'hFFFF);
        check("hdr_sat_all", hdr_err_cnt, model_cnt());

        // Reset with a stalled beat pending drops it and restores SEED/counters.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send({NL{64'h7777}}, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);
        rst = 1'b1;
        #1;
        sb_q.delete();
        for (int k = 0; k < NL; k++) begin
            m_state[k] = SEED_V;
            m_cnt[k] = '0;
        end
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_hdr_cnt", hdr_err_cnt, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send('0, {NL{2'b01}}, '0, 1'b0, 1'b0, 1'b0, e);
        check("post_rst_zero", out_data, {NL{2'b01, HAND_ZERO}});

        waitc = 0;
        while (sb_q.size() != 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scrambler_multilane.md
Name: scrambler_multilane

Overview:
Parametrised multi-lane 64b/66b scrambler/descrambler with polynomial x^58+x^39+1, self-synchronous. Each lane keeps an independent 58-bit state. The block runs in scramble mode on the TX path or descramble mode on the RX path, selected per transfer. It adds a valid/ready registered output stage, per-lane bypass, seed reload, and per-lane sync-header error counters. It sits between the gearbox and the lane framing logic.

Parameters:
- DATA_WIDTH, 64, payload bits per lane per transfer; must be ≥1.
- NUM_LANES, 4, number of independent lanes.
- SEED, 58'h3FF_FFFF_FFFF_FFFF, state value loaded on reset and on seed_load.
- CNT_WIDTH, 16, width of each header-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- descramble_mode  in  1  0 = scramble, 1 = descramble; sampled on each accepted transfer.
- seed_load  in  1  pulse; loads SEED into every lane state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  NUM_LANES*DATA_WIDTH  lane k occupies [k*DATA_WIDTH +: DATA_WIDTH]; bit 0 of each lane is processed first.
- in_sync  in  NUM_LANES*2  2-bit sync header per lane.
- in_bypass  in  NUM_LANES  per-lane bypass: data passes through unchanged and that lane's state is held.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_LANES*(DATA_WIDTH+2)  lane k layout is {sync[1:0], data[DATA_WIDTH-1:0]}.
- hdr_err_clr  in  1  clears all error counters.
- hdr_err_cnt  out  NUM_LANES*CNT_WIDTH  per-lane saturating count of invalid headers.

Behaviour:
- Reset (async): every lane state = SEED; out_valid = 0; out_data = 0; all hdr_err_cnt = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready.
  - On transfer, the output register loads on the next edge and out_valid is set to 1. Latency is 1 cycle.
  - When out_valid && out_ready and there is no new transfer, out_valid is cleared.
  - While out_valid && !out_ready, out_data stays stable.
- Per-lane bit loop, applied to a non-bypassed lane on transfer. For i = 0..DATA_WIDTH-1:
  - y[i] = x[i] ^ s[38] ^ s[57].
  - Then s = {s[56:0], fb}, where fb = y[i] in scramble mode and fb = x[i] in descramble mode.
  - The state register takes the final s.
- Bypassed lane: y = x and the state is unchanged.
- Sync header: passed through unmodified in every mode.
- Header error, descramble mode only:
  - A header of 2'b00 or 2'b11 on a transfer increments that lane's counter.
  - The counter saturates at all ones.
  - Bypassed lanes are still checked.
- hdr_err_clr:
  - Zeroes all counters on the next edge.
  - It takes priority over a same-cycle increment; that error is lost.
- seed_load:
  - Takes effect on the next edge for all lanes, including bypassed lanes.
  - If it coincides with a transfer, the output uses the old state and the state then becomes SEED. The seed wins over the updated state.
- No transfer: states hold, counters hold.
- A descramble_mode change between transfers does not touch the state.
- Reset mid-stream drops any pending out beat.

Decomposition:
- Package scrambler_pkg holds:
  - STATE_W = 58.
  - TAP_A = 38, TAP_B = 57.
  - HDR_DATA = 2'b01, HDR_CTRL = 2'b10.
  - Default SEED constant.
- One sub-module scrambler_lane contains a single lane's bit loop, state register, bypass, and error counter. The top level instantiates it NUM_LANES times and owns the handshake and output register.

Test Plan:
- Seed all ones, scramble, lane 0 data 64'h0, sync 2'b01, no backpressure -> one cycle later out lane0 = {2'b01, 64'h03FF_FF80_0000_0000}, out_valid = 1.
- Loopback: scramble 1000 random beats in four lanes, feed the output into a second instance in descramble mode -> recovered data and sync equal the original stimulus on every beat.
- Descrambler started with the wrong seed on scrambled traffic -> the first beat's output is erroneous; from the second beat onward the output exactly equals the original data (self-sync within 58 bits).
- Hold out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0 after the first beat, out_data stable, no state advance; release -> beats emerge in order, none lost or duplicated.
- Descramble mode, lane 2 headers 2'b00, 2'b11, 2'b01 -> hdr_err_cnt lane 2 = 2; then hdr_err_clr together with a 2'b11 header -> count = 0. Force 2^16+3 errors -> count = 16'hFFFF.
- in_bypass[1] = 1 with data 64'hDEAD_BEEF_0123_4567 -> lane 1 outputs it unchanged. The next unbypassed beat matches the reference model with lane 1 state unchanged. seed_load together with a transfer -> the output uses the old state and the following beat uses SEED.
